mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_mem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the core's instruction-fetch and data-access
// requests. An internal word-addressed RAM (asynchronous read, synchronous
// byte-masked write) answers both request types. Every instruction runs as one
// IDLE cycle, an optional DATA phase, and a FETCH phase. Each phase waits
// LATENCY cycles. `stall` holds the core until the fetch phase completes.
//
// Parameters
//   ADDR_W   word-address bits; the RAM holds 2**ADDR_W 32-bit words (1..29)
//   LATENCY  wait cycles per transaction (1..15)
//
// Ports
//   clk                  clock
//   reset                synchronous, active-high reset
//   fetch_addr           instruction byte address (combinational from the core)
//   fetch_request        a fetch is wanted
//   memory_addr          data byte address
//   write_data           store data, already lane-aligned
//   write_mask           byte enables, bit i enables write_data[8i+7:8i]
//   memory_request       current instruction performs a data access
//   memory_request_type  0 = load, 1 = store
//   fetch_data_valid     one-cycle pulse, request_data holds the instruction
//   memory_data_valid    one-cycle pulse, request_data holds the load word
//   request_data         shared response bus, zero when no valid is high
//   stall                core must hold PC, instruction, RF write and request
//   bus_error            (only with MEM_RESP_BUS_ERR_EN) one-cycle pulse aligned
//                        with the valid of an out-of-range fetch or data access
//
// Optional feature macro: MEM_RESP_BUS_ERR_EN
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_request,
  input  logic [31:0] memory_addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  input  logic        memory_request,
  input  logic        memory_request_type,
`ifdef MEM_RESP_BUS_ERR_EN
  output logic        bus_error,
`endif
  output logic        fetch_data_valid,
  output logic        memory_data_valid,
  output logic [31:0] request_data,
  output logic        stall
);

  // Illegal parameter values stop elaboration.
  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mem_responder: LATENCY must be within 1..15");
    end
    if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
      $error("mem_responder: ADDR_W must be within 1..29");
    end
  endgenerate

  localparam int         DEPTH      = 1 << ADDR_W;
  localparam logic [3:0] CNT_RELOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_FETCH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ram_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode. Byte-offset bits [1:0] are ignored. Any set bit above the
  // word index makes the access out of range.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] fetch_idx, mem_idx;
  logic              fetch_in_range, mem_in_range;
  logic [31:0]       fetch_rd_word, mem_rd_word;
  logic              unused_addr_lsbs;

  assign fetch_idx      = fetch_addr[ADDR_W+1:2];
  assign mem_idx        = memory_addr[ADDR_W+1:2];
  assign fetch_in_range = (fetch_addr[31:ADDR_W+2] == '0);
  assign mem_in_range   = (memory_addr[31:ADDR_W+2] == '0);

  // Asynchronous reads. Out-of-range reads return zero rather than an aliased word.
  assign fetch_rd_word  = fetch_in_range ? ram_q[fetch_idx] : 32'h0;
  assign mem_rd_word    = mem_in_range   ? ram_q[mem_idx]   : 32'h0;

  assign unused_addr_lsbs = ^{fetch_addr[1:0], memory_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Sequencing: IDLE -> [DATA] -> FETCH -> IDLE. cnt counts the remaining wait
  // cycles of the current phase. It is reloaded on every phase entry, so the
  // phase completes in the cycle where cnt reads zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fetch_request) begin
          cnt_d   = CNT_RELOAD;
          state_d = memory_request ? ST_DATA : ST_FETCH;
        end
      end
      ST_DATA: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d   = CNT_RELOAD;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Responses. These outputs are combinational on purpose. In IDLE, stall must
  // follow fetch_request in the same cycle. The completion cycle must return
  // data for the address the core presents in that cycle, because on a fetch
  // that address is the real next PC. Reset forces every output low.
  // ---------------------------------------------------------------------------
  logic data_done, fetch_done, store_commit;

  assign data_done  = !reset && (state_q == ST_DATA)  && (cnt_q == 4'd0);
  assign fetch_done = !reset && (state_q == ST_FETCH) && (cnt_q == 4'd0);

  // A store is written only in its completion cycle, in range, and outside reset.
  assign store_commit = data_done && memory_request_type && mem_in_range;

  always_comb begin
    stall             = 1'b0;
    fetch_data_valid  = 1'b0;
    memory_data_valid = 1'b0;
    request_data      = 32'h0;
    if (!reset) begin
      unique case (state_q)
        ST_IDLE:  stall = fetch_request;
        ST_DATA:  stall = 1'b1;
        ST_FETCH: stall = (cnt_q != 4'd0);
        default:  stall = 1'b0;
      endcase
    end
    if (data_done) begin
      memory_data_valid = 1'b1;
      request_data      = memory_request_type ? 32'h0 : mem_rd_word;
    end
    if (fetch_done) begin
      fetch_data_valid = 1'b1;
      request_data     = fetch_rd_word;
    end
  end

`ifdef MEM_RESP_BUS_ERR_EN
  assign bus_error = (data_done && !mem_in_range) || (fetch_done && !fetch_in_range);
`endif

  // ---------------------------------------------------------------------------
  // RAM write port. The RAM is not cleared by reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (store_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (write_mask[b]) begin
          ram_q[mem_idx][8*b +: 8] <= write_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] fa, ma, wd;
  logic [3:0]  wm;
  logic        mreq, mtype, fr1, fr2;
  logic        fdv1, mdv1, stall1, fdv2, mdv2, stall2;
  logic [31:0] rd1, rd2;
`ifdef MEM_RESP_BUS_ERR_EN
  logic        be1, be2;
`endif

  mem_responder #(.ADDR_W(ADDR_W), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .fetch_addr(fa), .fetch_request(fr2),
    .memory_addr(ma), .write_data(wd), .write_mask(wm),
    .memory_request(mreq), .memory_request_type(mtype),
`ifdef MEM_RESP_BUS_ERR_EN
    .bus_error(be2),
`endif
    .fetch_data_valid(fdv2), .memory_data_valid(mdv2),
    .request_data(rd2), .stall(stall2)
  );

  mem_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .fetch_addr(fa), .fetch_request(fr1),
    .memory_addr(ma), .write_data(wd), .write_mask(wm),
    .memory_request(mreq), .memory_request_type(mtype),
`ifdef MEM_RESP_BUS_ERR_EN
    .bus_error(be1),
`endif
    .fetch_data_valid(fdv1), .memory_data_valid(mdv1),
    .request_data(rd1), .stall(stall1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural memory model: word store indexed by word number.
  logic [31:0] ref_mem [int];

  function automatic bit m_in_range(input logic [31:0] a);
    return (a >> (ADDR_W + 2)) == 0;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_in_range(a)) return 32'h0;
    if (!ref_mem.exists(m_idx(a))) return 32'h0;
    return ref_mem[m_idx(a)];
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    if (!m_in_range(a)) return;
    w = m_read(a);
    for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[m_idx(a)] = w;
  endtask

  // One instruction: drive the request and follow it until stall drops.
  task automatic run_instr(input bit sel, input logic [31:0] fa_i, input logic mreq_i,
                           input logic mtype_i, input logic [31:0] ma_i,
                           input logic [31:0] wd_i, input logic [3:0] wm_i,
                           input logic [31:0] exp_m, input logic [31:0] exp_f,
                           input string tag);
    int lat = sel ? 1 : 2;
    int exp_cycles = 1 + lat + (mreq_i ? lat : 0);
    int cyc = 0, m_cnt = 0, f_cnt = 0, m_at = 0, f_at = 0;
    logic [31:0] m_data = 32'h0, f_data = 32'h0;
    bit bus_bad = 0, done = 0;
    logic s_stall, s_m, s_f;
    logic [31:0] s_rd;
`ifdef MEM_RESP_BUS_ERR_EN
    bit be_bad = 0;
    logic s_be;
`endif
    fa = fa_i; mreq = mreq_i; mtype = mtype_i; ma = ma_i; wd = wd_i; wm = wm_i;
    if (sel) fr1 = 1'b1; else fr2 = 1'b1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      s_stall = sel ? stall1 : stall2;
      s_m     = sel ? mdv1 : mdv2;
      s_f     = sel ? fdv1 : fdv2;
      s_rd    = sel ? rd1 : rd2;
      if (s_m) begin m_cnt++; m_at = cyc; m_data = s_rd; end
      if (s_f) begin f_cnt++; f_at = cyc; f_data = s_rd; end
      if (!s_m && !s_f && s_rd !== 32'h0) bus_bad = 1;
      if (s_m && s_f) bus_bad = 1;
`ifdef MEM_RESP_BUS_ERR_EN
      s_be = sel ? be1 : be2;
      if (s_be !== ((s_m && !m_in_range(ma_i)) || (s_f && !m_in_range(fa_i)))) be_bad = 1;
`endif
      done = (s_stall === 1'b0);
      @(posedge clk); #1;
    end
    chk($sformatf("%s_cycles", tag), 32'(cyc), 32'(exp_cycles));
    chk($sformatf("%s_mvalid_count", tag), 32'(m_cnt), mreq_i ? 32'd1 : 32'd0);
    chk($sformatf("%s_mvalid_cycle", tag), 32'(m_at), mreq_i ? 32'(1 + lat) : 32'd0);
    chk($sformatf("%s_mdata", tag), m_data, exp_m);
    chk($sformatf("%s_fvalid_count", tag), 32'(f_cnt), 32'd1);
    chk($sformatf("%s_fvalid_cycle", tag), 32'(f_at), 32'(exp_cycles));
    chk($sformatf("%s_fdata", tag), f_data, exp_f);
    chk($sformatf("%s_bus_idle_zero", tag), 32'(bus_bad), 32'd0);
`ifdef MEM_RESP_BUS_ERR_EN
    chk($sformatf("%s_bus_error", tag), 32'(be_bad), 32'd0);
`endif
  endtask

  typedef struct {
    logic [31:0] fa;
    logic        mreq;
    logic        mtype;
    logic [31:0] ma;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [31:0] em;
    logic [31:0] ef;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(7) == 0) return (32'($urandom_range(1, 16'hFFFF)) << (ADDR_W + 2)) | 32'($urandom_range(0, 63));
    return 32'($urandom_range(0, 63));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r_fa, r_ma, r_wd, r_em, r_ef;
    logic [3:0]  r_wm;
    logic        r_mreq, r_mtype;

    //                fetch        mreq  type  mem addr      wdata         mask   exp load      exp fetch
    tbl[0]  = '{32'h0001_0000, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_0013, 4'hF, 32'h0,        32'h0};
    tbl[1]  = '{32'h0001_0000, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0,        32'h0};
    tbl[2]  = '{32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 32'h1111_2222, 4'hF, 32'h0,        32'h1111_2222};
    tbl[3]  = '{32'h0000_0004, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0,        32'h0000_0013};
    tbl[4]  = '{32'h0000_0004, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_BEEF, 32'h0000_0013};
    tbl[5]  = '{32'h0000_0004, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_AB00, 4'h2, 32'h0,        32'h0000_0013};
    tbl[6]  = '{32'h0000_0100, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_ABEF, 32'hDEAD_ABEF};
    tbl[7]  = '{32'h0000_0004, 1'b1, 1'b0, 32'h0000_4000, 32'h0,         4'h0, 32'h0,        32'h0000_0013};
    tbl[8]  = '{32'h0000_0004, 1'b1, 1'b1, 32'h0000_4100, 32'hFFFF_FFFF, 4'hF, 32'h0,        32'h0000_0013};
    tbl[9]  = '{32'h0000_0006, 1'b1, 1'b0, 32'h0000_0103, 32'h0,         4'h0, 32'hDEAD_ABEF, 32'h0000_0013};
    tbl[10] = '{32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 32'hAA00_00BB, 4'h9, 32'h0,        32'hAA11_22BB};
    tbl[11] = '{32'h0001_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0,        32'h0};
    tbl[12] = '{32'h8000_0000, 1'b1, 1'b0, 32'h8000_0004, 32'h0,         4'h0, 32'h0,        32'h0};

    // Reset with requests pending: everything must stay quiet.
    reset = 1'b1; fr1 = 1'b1; fr2 = 1'b1; mreq = 1'b1; mtype = 1'b0;
    fa = 32'h0; ma = 32'h0; wd = 32'h0; wm = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_stall2", 32'(stall2), 32'd0);
    chk("rst_stall1", 32'(stall1), 32'd0);
    chk("rst_fvalid2", 32'(fdv2), 32'd0);
    chk("rst_mvalid2", 32'(mdv2), 32'd0);
    chk("rst_data2", rd2, 32'h0);
    @(posedge clk); #1;
    fr1 = 1'b0; fr2 = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("idle_stall2", 32'(stall2), 32'd0);
    chk("idle_fvalid2", 32'(fdv2), 32'd0);
    chk("idle_data2", rd2, 32'h0);
    @(posedge clk); #1;

    // Directed vectors on the LATENCY=2 instance.
    for (int i = 0; i < 13; i++) begin
      run_instr(1'b0, tbl[i].fa, tbl[i].mreq, tbl[i].mtype, tbl[i].ma, tbl[i].wd, tbl[i].wm,
                tbl[i].em, tbl[i].ef, $sformatf("vec%0d", i));
    end

    // Reset lands on the completion cycle of a store: it must not be written.
    fa = 32'h4; mreq = 1'b1; mtype = 1'b1; ma = 32'h100; wd = 32'h0; wm = 4'hF; fr2 = 1'b1;
    @(negedge clk);
    chk("rstseq_idle_stall", 32'(stall2), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstseq_wait_stall", 32'(stall2), 32'd1);
    chk("rstseq_wait_mvalid", 32'(mdv2), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstseq_stall", 32'(stall2), 32'd0);
    chk("rstseq_mvalid", 32'(mdv2), 32'd0);
    chk("rstseq_fvalid", 32'(fdv2), 32'd0);
    chk("rstseq_data", rd2, 32'h0);
    @(posedge clk); #1;
    fr2 = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstseq_after_stall", 32'(stall2), 32'd0);
    @(posedge clk); #1;
    run_instr(1'b0, 32'h4, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEAD_ABEF, 32'h13, "rstseq_reload");
    fr2 = 1'b0;

    // LATENCY=1 instance: preload, then three back-to-back fetches.
    run_instr(1'b1, 32'h0001_0000, 1'b1, 1'b1, 32'h8, 32'h1234_5678, 4'hF, 32'h0, 32'h0, "lat1_pre");
    fa = 32'h8; mreq = 1'b0; fr1 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("lat1_stall_c%0d", c), 32'(stall1), (c % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("lat1_fvalid_c%0d", c), 32'(fdv1), (c % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("lat1_data_c%0d", c), rd1, (c % 2 == 1) ? 32'h1234_5678 : 32'h0);
      @(posedge clk); #1;
    end
    fr1 = 1'b0;

    // Randomized traffic on the LATENCY=2 instance against the memory model.
    for (int i = 0; i < 16; i++) begin
      r_wd = $urandom;
      m_store(32'(i * 4), r_wd, 4'hF);
      run_instr(1'b0, 32'h0001_0000, 1'b1, 1'b1, 32'(i * 4), r_wd, 4'hF, 32'h0, 32'h0,
                $sformatf("rpre%0d", i));
    end
    for (int i = 0; i < 150; i++) begin
      r_fa    = rand_addr();
      r_ma    = rand_addr();
      r_mreq  = 1'($urandom_range(1));
      r_mtype = 1'($urandom_range(1));
      r_wd    = $urandom;
      r_wm    = 4'($urandom_range(15));
      r_em    = (r_mreq && !r_mtype) ? m_read(r_ma) : 32'h0;
      if (r_mreq && r_mtype) m_store(r_ma, r_wd, r_wm);
      r_ef    = m_read(r_fa);
      run_instr(1'b0, r_fa, r_mreq, r_mtype, r_ma, r_wd, r_wm, r_em, r_ef, $sformatf("rnd%0d", i));
    end
    fr2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
